// File: rtl/ternary_sampler.sv
// Ternary coefficient sampler: pulls coin words, slices them LSB-first into bytes
// and emits byte mod 3 as a 2-bit ternary coefficient per index, last index forced to 0.
module ternary_sampler #(
    parameter int N      = 701,
    parameter int COIN_W = 256,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COIN_W-1:0] coins,
    input  logic              coins_valid,
    output logic              coins_ready,
    output logic [1:0]        coef_out,
    output logic [IDX_W-1:0]  coef_idx,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    // Handshakes: a word/coefficient moves on a rising edge where valid and ready
    // are both high. coins_ready and coef_valid decode from the state register only,
    // so they never depend on the partner's inputs and are never high together.

    localparam int BYTES = COIN_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_SAMPLED = IDX_W'(N - 2);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
    localparam logic [BC_W-1:0]  LAST_BYTE    = BC_W'(BYTES - 1);
    localparam logic [BC_W-1:0]  BC_ONE       = BC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EMIT = 3'd2,
        S_LAST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx;
    logic [BC_W-1:0]   byte_cnt;
    logic [COIN_W-1:0] shreg;
    logic [1:0]        byte_coef;

    // Residue mod 3 by folding base-4 digits (4 = 1 mod 3) until the sum is <= 4.
    function automatic logic [1:0] mod3(input logic [7:0] b);
        logic [3:0] s4;
        logic [2:0] s3;
        logic [2:0] s2;
        logic [2:0] r;
        s4 = {2'b00, b[7:6]} + {2'b00, b[5:4]} + {2'b00, b[3:2]} + {2'b00, b[1:0]};
        s3 = {1'b0, s4[3:2]} + {1'b0, s4[1:0]};
        s2 = {2'b00, s3[2]} + {1'b0, s3[1:0]};
        r  = (s2 >= 3'd3) ? (s2 - 3'd3) : s2;
        return r[1:0];
    endfunction

    assign byte_coef = mod3(shreg[7:0]);
    assign coef_idx  = idx;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        coins_ready = 1'b0;
        coef_valid  = 1'b0;
        coef_out    = 2'b00;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_n = S_LOAD;
            end
            S_LOAD: begin
                coins_ready = 1'b1;
                if (coins_valid) state_n = S_EMIT;
            end
            S_EMIT: begin
                coef_valid = 1'b1;
                coef_out   = byte_coef;
                if (coef_ready) begin
                    if (idx == LAST_SAMPLED) begin
                        state_n = S_LAST;
                    end else if (byte_cnt == LAST_BYTE) begin
                        state_n = S_LOAD;
                    end
                end
            end
            S_LAST: begin
                coef_valid = 1'b1;
                if (coef_ready) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // In LAST, idx already holds N-1 from the final EMIT increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) idx <= '0;
                end
                S_LOAD: begin
                    if (coins_valid) begin
                        shreg    <= coins;
                        byte_cnt <= '0;
                    end
                end
                S_EMIT: begin
                    if (coef_ready) begin
                        idx      <= idx + IDX_ONE;
                        byte_cnt <= byte_cnt + BC_ONE;
                        shreg    <= shreg >> 8;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
